// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: sequences word stores directly and half/byte stores as read-modify-write into word memory
module store_rmw_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_req,
  input  logic [1:0]  st_ss_ctrl,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_done,
  output logic        st_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;
  state_t      state;
  logic [1:0]  req_ss, req_off;
  logic [15:0] req_data;
  logic [2:0]  cnt;
  logic [31:0] merged;
  logic        bad;
  assign st_ready = state == IDLE;
  assign bad = st_ss_ctrl == 2'b11 || (st_ss_ctrl == 2'b01 && st_addr[0]) ||
               (st_ss_ctrl == 2'b00 && st_addr[1:0] != 2'b00);
  always_comb begin
    merged = mem_rdata;
    if (req_ss == 2'b10) merged[{req_off, 3'b000} +: 8] = req_data[7:0];
    else merged[{req_off[1], 4'b0000} +: 16] = req_data;
  end
  // mem_wdata doubles as the merge register for sub-word stores
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      req_ss    <= '0;
      req_off   <= '0;
      req_data  <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (st_req) begin
          req_ss    <= st_ss_ctrl;
          req_off   <= st_addr[1:0];
          req_data  <= st_data[15:0];
          mem_addr  <= {st_addr[31:2], 2'b00};
          mem_wdata <= st_data;
          state     <= bad ? ERR : st_ss_ctrl == 2'b00 ? WRITE : READ;
          st_err    <= bad;
          mem_wr    <= !bad && st_ss_ctrl == 2'b00;
          st_done   <= !bad && st_ss_ctrl == 2'b00;
          mem_rd    <= !bad && st_ss_ctrl != 2'b00;
        end
        READ: begin
          mem_rd <= 1'b0;
          cnt    <= 3'(MEM_LAT);
          state  <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
            st_done   <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          mem_wr  <= 1'b0;
          st_done <= 1'b0;
          state   <= IDLE;
        end
        ERR: begin
          st_err <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_store_rmw_ctrl.sv
// tb_store_rmw_ctrl: two instances (MEM_LAT 1 and 3) checked against a queue-based reference model
module tb_store_rmw_ctrl;
  typedef struct {
    bit          err;
    bit          sub;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        st_req [2];
  logic [1:0]  st_ss_ctrl [2];
  logic [31:0] st_addr [2];
  logic [31:0] st_data [2];
  logic        st_ready [2];
  logic        st_done [2];
  logic        st_err [2];
  logic        mem_rd [2];
  logic        mem_wr [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  exp_t        sbq [2][$];
  logic [31:0] ref_mem [2][32];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          exp_rdy [2] = '{0, 0};
  int          wr_cnt [2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = g == 0 ? 1 : 3;
    logic [31:0] mem [32];
    int          cnt = 0;
    logic [4:0]  raddr = '0;
    logic [31:0] garb = '0;
    exp_t        e;
    store_rmw_ctrl #(.MEM_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .st_req(st_req[g]), .st_ss_ctrl(st_ss_ctrl[g]),
      .st_addr(st_addr[g]), .st_data(st_data[g]), .st_ready(st_ready[g]), .st_done(st_done[g]),
      .st_err(st_err[g]), .mem_addr(mem_addr[g]), .mem_rd(mem_rd[g]), .mem_wr(mem_wr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
    // memory: data valid exactly LAT cycles after the read strobe, random junk otherwise
    always @(posedge clk) begin
      garb <= $urandom;
      if (!reset_n) begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'h11223344;
        cnt <= 0;
      end else begin
        if (mem_wr[g]) mem[mem_addr[g][6:2]] <= mem_wdata[g];
        if (mem_rd[g]) begin
          cnt   <= LAT;
          raddr <= mem_addr[g][6:2];
        end else if (cnt > 0) cnt <= cnt - 1;
      end
    end
    assign mem_rdata[g] = cnt == 1 ? mem[raddr] : garb;
    always @(negedge clk) if (reset_n) begin
      if (mem_rd[g] || mem_wr[g]) chk("rd_wr_exclusive", 32'(mem_rd[g] & mem_wr[g]), 0);
      if (st_done[g] || mem_wr[g]) chk("done_with_write", 32'(st_done[g]), 32'(mem_wr[g]));
      if (mem_rd[g]) begin
        chk("rd_pending", 32'(sbq[g].size()), 1);
        if (sbq[g].size() > 0) begin
          e = sbq[g][0];
          chk("rd_addr", mem_addr[g], e.addr);
          chk("rd_cycle", cyc, e.sub ? e.acc + 1 : -1);
        end
      end
      if (mem_wr[g]) wr_cnt[g]++;
      if (mem_wr[g] || st_err[g]) begin
        chk("op_pending", 32'(sbq[g].size()), 1);
        if (sbq[g].size() > 0) begin
          e = sbq[g].pop_front();
          chk("err_flag", 32'(st_err[g]), 32'(e.err));
          if (mem_wr[g]) begin
            chk("wr_addr", mem_addr[g], e.addr);
            chk("wr_data", mem_wdata[g], e.wdata);
            chk("wr_cycle", cyc, e.acc + (e.sub ? 2 + LAT : 1));
          end else chk("err_cycle", cyc, e.acc + 1);
        end
      end
    end
  end

  task automatic issue(input int g, input logic [1:0] ss, input logic [31:0] a, input logic [31:0] d,
                       input bit has_exp, input logic [31:0] xw);
    exp_t e;
    int n = 0;
    int start = cyc;
    int lat = g == 0 ? 1 : 3;
    logic [31:0] mask, nw;
    while (!st_ready[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready[g]) begin
      chk("ready_timeout", 32'(st_ready[g]), 1);
      return;
    end
    if (start <= exp_rdy[g]) chk("ready_latency", cyc, exp_rdy[g]);
    e.err = ss == 2'b11 || (ss == 2'b01 && a[0]) || (ss == 2'b00 && a[1:0] != 2'b00);
    e.sub = !e.err && ss != 2'b00;
    e.addr = a & ~32'h3;
    e.wdata = '0;
    if (!e.err) begin
      mask = (ss == 2'b10 ? 32'hFF : 32'hFFFF) << (8 * a[1:0]);
      nw = ss == 2'b00 ? d : (ref_mem[g][a[6:2]] & ~mask) | ((d << (8 * a[1:0])) & mask);
      ref_mem[g][a[6:2]] = nw;
      e.wdata = has_exp ? xw : nw;
    end
    e.acc = cyc;
    sbq[g].push_back(e);
    exp_rdy[g] = cyc + (e.sub ? 3 + lat : 2);
    st_req[g] = 1'b1;
    st_ss_ctrl[g] = ss;
    st_addr[g] = a;
    st_data[g] = d;
    @(negedge clk);
    st_req[g] = 1'($urandom_range(0, 1));
    st_ss_ctrl[g] = 2'($urandom_range(0, 3));
    st_addr[g] = $urandom;
    st_data[g] = $urandom;
    @(negedge clk);
    st_req[g] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq[0].size() + sbq[1].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sbq[0].size() + sbq[1].size()), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [1:0] ss;
    logic [31:0] a;
    int w0;
    for (int g = 0; g < 2; g++) begin
      st_req[g] = 1'b0;
      st_ss_ctrl[g] = '0;
      st_addr[g] = '0;
      st_data[g] = '0;
      for (int i = 0; i < 32; i++) ref_mem[g][i] = 32'h11223344;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", 32'(st_ready[g]), 1);
      chk("rst_rd", 32'(mem_rd[g]), 0);
      chk("rst_wr", 32'(mem_wr[g]), 0);
      chk("rst_done", 32'(st_done[g]), 0);
      chk("rst_err", 32'(st_err[g]), 0);
      chk("rst_addr", mem_addr[g], 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    issue(0, 2'b00, 32'h10, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    issue(0, 2'b10, 32'h22, 32'h000000AB, 1, 32'h11AB3344);
    issue(1, 2'b01, 32'h42, 32'h0000CAFE, 1, 32'hCAFE3344);
    issue(0, 2'b01, 32'h43, 32'h1234, 0, 0);
    issue(0, 2'b00, 32'h06, 32'h55667788, 0, 0);
    issue(0, 2'b11, 32'h100, 32'h99, 0, 0);
    issue(0, 2'b00, 32'h14, 32'h0BADF00D, 1, 32'h0BADF00D);
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 40; i++) begin
        ss = 2'($urandom_range(0, 3));
        a = $urandom;
        if ($urandom_range(0, 1) == 1)
          a[1:0] = ss == 2'b00 ? 2'b00 : (ss == 2'b01 ? {a[1], 1'b0} : a[1:0]);
        issue(g, ss, a, $urandom, 0, 0);
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    drain();
    issue(1, 2'b10, 32'h31, 32'h0000005A, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("abort_ready", 32'(st_ready[1]), 1);
    chk("abort_rd", 32'(mem_rd[1]), 0);
    chk("abort_wr", 32'(mem_wr[1]), 0);
    sbq[0].delete();
    sbq[1].delete();
    for (int g = 0; g < 2; g++) for (int i = 0; i < 32; i++) ref_mem[g][i] = 32'h11223344;
    w0 = wr_cnt[1];
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_rdy = '{0, 0};
    repeat (8) @(negedge clk);
    chk("no_write_after_abort", wr_cnt[1], w0);
    issue(1, 2'b00, 32'h44, 32'h12345678, 1, 32'h12345678);
    issue(1, 2'b10, 32'h31, 32'h0000005A, 1, 32'h11225A44);
    drain();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
